// File: rtl/ce_phase_monitor.sv
// ce_phase_monitor
//   Receive-side checker for the 24 MHz clock-enable strobe set. It recovers
//   the generator's phase counter from the pipe_ab rising edge and then
//   compares every strobe against the pattern expected for that phase on
//   every clk24 edge. It reports lock, the recovered phase and sticky error
//   information.
//
// Ports
//   clk24        in   24 MHz clock; all strobes are sampled on its rising edge
//   reset        in   synchronous, active-high reset
//   ce12 .. pipe_ab in strobes under test
//   clr_err      in   synchronous clear of err_count / err_mask
//   locked       out  phase recovered and verified
//   phase        out  expected phase of the strobes presented this cycle
//   err_count    out  saturating count of mismatch events while locked
//   err_mask     out  sticky mismatch bits
//                     [0]ce12 [1]ce6 [2]ce3 [3]ce3v [4]video_slice [5]ce1m5 [6]pipe_ab
//   err_strobe   out  one-cycle pulse per counted error
//   state_dbg    out  current FSM state (0 HUNT, 1 VERIFY, 2 LOCKED)
module ce_phase_monitor #(
  parameter int PIPE_BIT     = 4,
  parameter int LOCK_PERIODS = 2,
  parameter int ERR_W        = 8
) (
  input  logic              clk24,
  input  logic              reset,
  input  logic              ce12,
  input  logic              ce6,
  input  logic              ce3,
  input  logic              ce3v,
  input  logic              video_slice,
  input  logic              ce1m5,
  input  logic              pipe_ab,
  input  logic              clr_err,
  output logic              locked,
  output logic [PIPE_BIT:0] phase,
  output logic [ERR_W-1:0]  err_count,
  output logic [6:0]        err_mask,
  output logic              err_strobe,
  output logic [1:0]        state_dbg
);

  localparam int P  = PIPE_BIT + 1;
  // The pattern uses phase bits up to c[3]; widen so that index is always legal.
  localparam int CW = (P > 6) ? P : 6;
  localparam int N  = LOCK_PERIODS * (2 ** P);
  localparam int GW = $clog2(N + 1);

  // The acquisition sample is phase 2^PIPE_BIT, so the next sample is one more.
  localparam logic [P-1:0]     ACQ_NEXT  = P'((2 ** PIPE_BIT) + 1);
  localparam logic [GW-1:0]    GOOD_LAST = GW'(N - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [P-1:0]    exp_ph;
  logic [GW-1:0]   good_cnt;
  logic            prev_pipe;

  logic [CW-1:0]   c;
  logic [6:0]      obs, expv, mism_vec;
  logic            mism, rise;
  logic            acquire, advance, err_hit;
  logic [ERR_W-1:0] cnt_base, err_count_nxt;
  logic [6:0]      mask_base, err_mask_nxt;

  // Expected strobe pattern for the phase held in exp_ph.
  always_comb begin
    c        = CW'(exp_ph);
    expv[0]  = c[0];
    expv[1]  = c[1] & c[0];
    expv[2]  = c[2] & ~c[1] & c[0];
    expv[3]  = c[2] & c[1] & ~c[0];
    expv[4]  = ~c[2];
    expv[5]  = c[3] & c[2] & ~c[1] & c[0];
    expv[6]  = c[PIPE_BIT];
    obs      = {pipe_ab, ce1m5, video_slice, ce3v, ce3, ce6, ce12};
    mism_vec = obs ^ expv;
    mism     = |mism_vec;
    rise     = pipe_ab & ~prev_pipe;
  end

  // State register
  always_ff @(posedge clk24) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  // Next-state logic. A mismatching sample during VERIFY that is also a
  // pipe_ab rise is taken as a fresh acquisition rather than wasted.
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (rise) state_nxt = VERIFY;
      VERIFY: begin
        if (mism)                       state_nxt = rise ? VERIFY : HUNT;
        else if (good_cnt == GOOD_LAST) state_nxt = LOCKED;
      end
      LOCKED:  if (mism) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // Output / control decode
  always_comb begin
    locked    = (state == LOCKED);
    state_dbg = state;
    phase     = exp_ph;
    acquire   = rise & ((state == HUNT) | ((state == VERIFY) & mism));
    advance   = ((state == VERIFY) | (state == LOCKED)) & ~mism;
    err_hit   = (state == LOCKED) & mism;

    // clr_err takes effect before a same-edge error is accumulated.
    cnt_base  = clr_err ? '0 : err_count;
    mask_base = clr_err ? '0 : err_mask;
    err_count_nxt = cnt_base;
    err_mask_nxt  = mask_base;
    if (err_hit) begin
      err_count_nxt = (cnt_base == ERR_MAX) ? cnt_base : cnt_base + ERR_W'(1);
      err_mask_nxt  = mask_base | mism_vec;
    end
  end

  // Phase tracker, lock qualification counter and error bookkeeping
  always_ff @(posedge clk24) begin
    if (reset) begin
      exp_ph     <= '0;
      good_cnt   <= '0;
      prev_pipe  <= 1'b0;
      err_count  <= '0;
      err_mask   <= '0;
      err_strobe <= 1'b0;
    end else begin
      prev_pipe <= pipe_ab;
      if (acquire) begin
        exp_ph   <= ACQ_NEXT;
        good_cnt <= '0;
      end else if (advance) begin
        exp_ph <= exp_ph + P'(1);
        if (state == VERIFY) good_cnt <= good_cnt + GW'(1);
      end
      err_strobe <= err_hit;
      err_count  <= err_count_nxt;
      err_mask   <= err_mask_nxt;
    end
  end

endmodule

// File: tb/tb_ce_phase_monitor.sv
// Directed bench for ce_phase_monitor. Three instances share one generator
// model: dut_a (PIPE_BIT=4, LOCK_PERIODS=2), dut_b (PIPE_BIT=5,
// LOCK_PERIODS=1) and dut_c (ERR_W=2). Each has its own fault-injection mask.
module tb_ce_phase_monitor;

  // Clock / reset
  logic clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  logic reset   = 1'b1;
  logic clr_err = 1'b0;

  logic [6:0] in_a = '0, in_b = '0, in_c = '0;
  logic [6:0] flt_a = '0, flt_b = '0, flt_c = '0;

  logic       locked_a, locked_b, locked_c;
  logic [4:0] phase_a, phase_c;
  logic [5:0] phase_b;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [6:0] mask_a, mask_b, mask_c;
  logic       stb_a, stb_b, stb_c;
  logic [1:0] st_a, st_b, st_c;

  ce_phase_monitor #(.PIPE_BIT(4), .LOCK_PERIODS(2), .ERR_W(8)) dut_a (
    .clk24(clk24), .reset(reset),
    .ce12(in_a[0]), .ce6(in_a[1]), .ce3(in_a[2]), .ce3v(in_a[3]),
    .video_slice(in_a[4]), .ce1m5(in_a[5]), .pipe_ab(in_a[6]),
    .clr_err(clr_err), .locked(locked_a), .phase(phase_a),
    .err_count(cnt_a), .err_mask(mask_a), .err_strobe(stb_a), .state_dbg(st_a)
  );

  ce_phase_monitor #(.PIPE_BIT(5), .LOCK_PERIODS(1), .ERR_W(8)) dut_b (
    .clk24(clk24), .reset(reset),
    .ce12(in_b[0]), .ce6(in_b[1]), .ce3(in_b[2]), .ce3v(in_b[3]),
    .video_slice(in_b[4]), .ce1m5(in_b[5]), .pipe_ab(in_b[6]),
    .clr_err(clr_err), .locked(locked_b), .phase(phase_b),
    .err_count(cnt_b), .err_mask(mask_b), .err_strobe(stb_b), .state_dbg(st_b)
  );

  ce_phase_monitor #(.PIPE_BIT(4), .LOCK_PERIODS(2), .ERR_W(2)) dut_c (
    .clk24(clk24), .reset(reset),
    .ce12(in_c[0]), .ce6(in_c[1]), .ce3(in_c[2]), .ce3v(in_c[3]),
    .video_slice(in_c[4]), .ce1m5(in_c[5]), .pipe_ab(in_c[6]),
    .clr_err(clr_err), .locked(locked_c), .phase(phase_c),
    .err_count(cnt_c), .err_mask(mask_c), .err_strobe(stb_c), .state_dbg(st_c)
  );

  // Generator model: mc counts samples since the start-up hold ended.
  int   mc      = 0;
  logic running = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  function automatic logic [6:0] pat(input logic [5:0] c, input int pb);
    logic [6:0] p;
    p[0] = c[0];
    p[1] = c[1] & c[0];
    p[2] = c[2] & ~c[1] & c[0];
    p[3] = c[2] & c[1] & ~c[0];
    p[4] = ~c[2];
    p[5] = c[3] & c[2] & ~c[1] & c[0];
    p[6] = c[pb];
    return p;
  endfunction

  // Driver: present the sample for mc, clock it in, then step the model.
  task automatic tick();
    logic [5:0] c;
    c = mc[5:0];
    if (running) begin
      in_a = pat(c, 4) ^ flt_a;
      in_b = pat(c, 5) ^ flt_b;
      in_c = pat(c, 4) ^ flt_c;
    end else begin
      in_a = '0;
      in_b = '0;
      in_c = '0;
    end
    @(posedge clk24);
    #1;
    if (running) mc++;
  endtask

  task automatic run_to(input int ph, input int md);
    while ((mc % md) != ph) tick();
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bounded wait for relock of dut_a (which=0) or dut_c (which=1).
  task automatic wait_lock(input int which);
    for (int i = 0; i < 200; i++) begin
      if ((which == 0) ? locked_a : locked_c) break;
      tick();
    end
    chk(which == 0 ? "relock_a" : "relock_c", (which == 0) ? locked_a : locked_c, 1);
  endtask

  int acq;

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_locked_a", locked_a, 0);
    chk("rst_phase_a",  phase_a,  0);
    chk("rst_cnt_a",    cnt_a,    0);
    chk("rst_mask_a",   mask_a,   0);
    chk("rst_stb_a",    stb_a,    0);
    chk("rst_locked_b", locked_b, 0);
    chk("rst_phase_b",  phase_b,  0);
    reset = 1'b0;

    // 24-cycle all-zero start-up hold: no acquisition, no errors
    repeat (24) tick();
    chk("hold_state_a",  st_a,     0);
    chk("hold_locked_a", locked_a, 0);
    chk("hold_cnt_a",    cnt_a,    0);
    chk("hold_mask_a",   mask_a,   0);

    // Clean run: first rise at sample 16, locked after sample 80
    running = 1'b1;
    while (mc < 80) tick();
    chk("lock_early_a", locked_a, 0);
    chk("lock_early_c", locked_c, 0);
    tick();
    chk("lock_edge_a",  locked_a, 1);
    chk("lock_edge_c",  locked_c, 1);
    chk("lock_phase_a", phase_a,  17);

    // PIPE_BIT=5: acquisition at sample 32, locked after sample 96
    while (mc < 96) tick();
    chk("lock_early_b", locked_b, 0);
    tick();
    chk("lock_edge_b",  locked_b, 1);
    chk("lock_phase_b", phase_b,  33);

    // Phase tracking over the long clean run (dut_b wraps 63 -> 0 repeatedly)
    while (mc < 10000) begin
      tick();
      chk("track_phase_a", phase_a, mc % 32);
      chk("track_phase_b", phase_b, mc % 64);
      chk("track_phase_c", phase_c, mc % 32);
      chk("track_locked_a", locked_a, 1);
    end
    chk("clean_cnt_a", cnt_a, 0);
    chk("clean_cnt_b", cnt_b, 0);
    chk("clean_cnt_c", cnt_c, 0);

    // Locked fault: ce3 forced low at phase 13
    run_to(13, 32);
    flt_a = 7'b0000100;
    tick();
    flt_a = '0;
    chk("ce3_stb",    stb_a,    1);
    chk("ce3_cnt",    cnt_a,    1);
    chk("ce3_mask",   mask_a,   7'b0000100);
    chk("ce3_locked", locked_a, 0);
    acq = mc + 2;
    tick();
    chk("ce3_stb_once", stb_a, 0);
    while (mc < acq + 64) tick();
    chk("ce3_relock_early", locked_a, 0);
    tick();
    chk("ce3_relock_edge", locked_a, 1);

    // Second locked fault (ce12 at phase 3) to reach err_count=2
    run_to(3, 32);
    flt_a = 7'b0000001;
    tick();
    flt_a = '0;
    chk("ce12_cnt",  cnt_a,  2);
    chk("ce12_mask", mask_a, 7'b0000101);
    wait_lock(0);

    // One-cycle reset while locked (phase 5 of the 64-cycle frame)
    run_to(5, 64);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_locked", locked_a, 0);
    chk("mrst_cnt",    cnt_a,    0);
    chk("mrst_mask",   mask_a,   0);
    chk("mrst_phase",  phase_a,  0);
    chk("mrst_stb",    stb_a,    0);

    // Fault during VERIFY: ce1m5 low at phase 29, 13 samples after acquisition
    run_to(29, 32);
    flt_a = 7'b0100000;
    tick();
    flt_a = '0;
    chk("vfy_locked", locked_a, 0);
    chk("vfy_cnt",    cnt_a,    0);
    chk("vfy_mask",   mask_a,   0);
    chk("vfy_stb",    stb_a,    0);
    acq = mc + 18;
    while (mc < acq + 64) tick();
    chk("vfy_relock_early", locked_a, 0);
    tick();
    chk("vfy_relock_edge", locked_a, 1);
    chk("vfy_relock_cnt",  cnt_a,    0);

    // ERR_W=2: five video_slice faults saturate the counter at 3
    wait_lock(1);
    for (int k = 0; k < 5; k++) begin
      run_to(3, 32);
      flt_c = 7'b0010000;
      tick();
      flt_c = '0;
      chk("vs_stb", stb_c, 1);
      chk("vs_cnt", cnt_c, (k < 3) ? k + 1 : 3);
      wait_lock(1);
    end
    chk("vs_mask", mask_c, 7'b0010000);

    // clr_err on the same edge as a ce12 fault: clear applies first
    run_to(3, 32);
    clr_err = 1'b1;
    flt_c = 7'b0000001;
    tick();
    clr_err = 1'b0;
    flt_c = '0;
    chk("clr_cnt",    cnt_c,    1);
    chk("clr_mask",   mask_c,   7'b0000001);
    chk("clr_locked", locked_c, 0);
    chk("final_cnt_b", cnt_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
